// File: rtl/mw_skid_buffer.sv
// ----------------------------------------------------------------------------
// mw_skid_buffer
//
// Memory -> write-back stage register with a valid/ready handshake and a
// two-entry skid store. The registered "main" entry always drives the
// outputs. The "skid" entry catches one extra word when the consumer stalls
// while a word is still arriving. in_ready is decoded only from registered
// state (and rst), so there is no combinational path from out_ready to
// in_ready. A synchronous flush empties the buffer and presents a bubble.
//
// State table:
//   state | meaning
//   EMPTY | nothing held, outputs show a bubble (ctrl_out = 0)
//   ONE   | main holds the word on the outputs, skid unused
//   FULL  | main on the outputs, skid holds the next word, in_ready = 0
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (beats flush and handshake)
//   flush      synchronous squash of all held entries
//   in_valid   upstream word present
//   in_ready   buffer accepts a word this cycle
//   ctrl_in    control bundle from the memory stage
//   data_in    ALU/memory result
//   addr_in    destination register address
//   out_valid  output word present
//   out_ready  write-back stage consumes the word
//   ctrl_out   control bundle to write-back, forced to 0 when out_valid = 0
//   data_out   result to write-back
//   addr_out   destination register address to write-back
//   occupancy  number of entries held (0..2)
// ----------------------------------------------------------------------------
module mw_skid_buffer #(
    parameter int CTRL_W = 3,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] addr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr_out,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CTRL_W-1:0] main_ctrl_q;
    logic [DATA_W-1:0] main_data_q;
    logic [ADDR_W-1:0] main_addr_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;
    logic [ADDR_W-1:0] skid_addr_q;

    logic push;
    logic pop;
    logic main_from_in;
    logic main_from_skid;
    logic skid_from_in;

    // rst is folded in so upstream sees the buffer as busy during reset.
    assign in_ready  = (state_q != FULL) && !rst;
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = state_q;

    // Gating ctrl turns an empty buffer into a bubble with all write enables
    // low; data/addr are left ungated since consumers qualify them on ctrl.
    assign ctrl_out = out_valid ? main_ctrl_q : '0;
    assign data_out = main_data_q;
    assign addr_out = main_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_addr_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_addr_q <= '0;
        end else begin
            state_q <= state_d;
            if (main_from_in) begin
                main_ctrl_q <= ctrl_in;
                main_data_q <= data_in;
                main_addr_q <= addr_in;
            end else if (main_from_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
                main_addr_q <= skid_addr_q;
            end
            if (skid_from_in) begin
                skid_ctrl_q <= ctrl_in;
                skid_data_q <= data_in;
                skid_addr_q <= addr_in;
            end
        end
    end

    // Flush only drops the state; entry registers keep their contents and
    // are simply no longer considered valid.
    always_comb begin
        state_d        = state_q;
        main_from_in   = 1'b0;
        main_from_skid = 1'b0;
        skid_from_in   = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d      = ONE;
                        main_from_in = 1'b1;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_from_in = 1'b1;
                    end else if (push) begin
                        state_d      = FULL;
                        skid_from_in = 1'b1;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d        = ONE;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_mw_skid_buffer.sv
// ----------------------------------------------------------------------------
// tb_mw_skid_buffer
//
// Directed checks of reset, streaming, back-pressure, flush and reset
// mid-transfer, followed by a random valid/ready run against a queue model
// of the expected word order and an independent occupancy model.
// Inputs are driven 1 ns after the rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_mw_skid_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  ctrl_in;
    logic [15:0] data_in;
    logic [2:0]  addr_in;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  ctrl_out;
    logic [15:0] data_out;
    logic [2:0]  addr_out;
    logic [1:0]  occupancy;

    int vectors    = 0;
    int miscompares = 0;

    mw_skid_buffer #(.CTRL_W(3), .DATA_W(16), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ctrl_in   (ctrl_in),
        .data_in   (data_in),
        .addr_in   (addr_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ctrl_out  (ctrl_out),
        .data_out  (data_out),
        .addr_out  (addr_out),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [15:0] d, input logic [2:0] a);
        in_valid = v;
        ctrl_in  = c;
        data_in  = d;
        addr_in  = a;
    endtask

    logic [21:0] sb_q[$];
    logic [21:0] exp_word;
    int          model_occ;
    int          n_in;
    int          n_out;
    int          cycles;
    logic        do_push;
    logic        do_pop;
    logic        seen_bad;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 3'd0);

        // ---- reset ----
        step();
        step();
        chk("in_ready_during_rst", in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_ctrl_out",  ctrl_out,  3'd0);
        chk("rst_data_out",  data_out,  16'h0);
        chk("rst_addr_out",  addr_out,  3'd0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_in_ready",  in_ready,  1'b1);

        // ---- streaming with out_ready = 1 ----
        out_ready = 1'b1;
        drive(1'b1, 3'b101, 16'hA5A5, 3'd4);
        step();
        chk("strm_a_valid", out_valid, 1'b1);
        chk("strm_a_ctrl",  ctrl_out,  3'b101);
        chk("strm_a_data",  data_out,  16'hA5A5);
        chk("strm_a_addr",  addr_out,  3'd4);
        chk("strm_a_occ",   occupancy, 2'd1);
        chk("strm_a_rdy",   in_ready,  1'b1);
        drive(1'b1, 3'b011, 16'h1234, 3'd2);
        step();
        chk("strm_b_valid", out_valid, 1'b1);
        chk("strm_b_ctrl",  ctrl_out,  3'b011);
        chk("strm_b_data",  data_out,  16'h1234);
        chk("strm_b_addr",  addr_out,  3'd2);
        chk("strm_b_occ",   occupancy, 2'd1);
        chk("strm_b_rdy",   in_ready,  1'b1);
        drive(1'b0, 3'd0, 16'h0, 3'd0);
        step();
        chk("strm_drain_valid", out_valid, 1'b0);
        chk("strm_drain_ctrl",  ctrl_out,  3'd0);
        chk("strm_drain_occ",   occupancy, 2'd0);

        // ---- back-pressure ----
        out_ready = 1'b0;
        drive(1'b1, 3'b001, 16'h0001, 3'd1);
        step();
        chk("bp_1_occ", occupancy, 2'd1);
        drive(1'b1, 3'b010, 16'h0002, 3'd2);
        step();
        chk("bp_2_occ",  occupancy, 2'd2);
        chk("bp_2_rdy",  in_ready,  1'b0);
        chk("bp_2_data", data_out,  16'h0001);
        chk("bp_2_ctrl", ctrl_out,  3'b001);
        drive(1'b1, 3'b100, 16'h0003, 3'd3);
        step();
        chk("bp_3_occ",  occupancy, 2'd2);
        chk("bp_3_data", data_out,  16'h0001);
        drive(1'b0, 3'd0, 16'h0, 3'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_out1_data", data_out, 16'h0001);
        step();
        chk("bp_out2_data",  data_out,  16'h0002);
        chk("bp_out2_ctrl",  ctrl_out,  3'b010);
        chk("bp_out2_addr",  addr_out,  3'd2);
        chk("bp_out2_occ",   occupancy, 2'd1);
        step();
        chk("bp_end_valid", out_valid, 1'b0);
        chk("bp_end_ctrl",  ctrl_out,  3'd0);
        chk("bp_end_occ",   occupancy, 2'd0);

        // ---- flush while FULL ----
        out_ready = 1'b0;
        drive(1'b1, 3'b110, 16'h0011, 3'd5);
        step();
        drive(1'b1, 3'b011, 16'h0022, 3'd6);
        step();
        chk("fl_pre_occ", occupancy, 2'd2);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 3'b111, 16'hBEEF, 3'd7);
        step();
        flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 3'd0);
        chk("fl_occ",   occupancy, 2'd0);
        chk("fl_valid", out_valid, 1'b0);
        chk("fl_ctrl",  ctrl_out,  3'd0);
        chk("fl_rdy",   in_ready,  1'b1);
        chk("fl_data_hold", data_out, 16'h0011);
        seen_bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid && data_out == 16'hBEEF) seen_bad = 1'b1;
            if (out_valid) seen_bad = 1'b1;
        end
        chk("fl_no_beef", seen_bad, 1'b0);

        // ---- reset mid-operation ----
        out_ready = 1'b0;
        drive(1'b1, 3'b111, 16'h0077, 3'd7);
        step();
        chk("rm_pre_occ",  occupancy, 2'd1);
        chk("rm_pre_ctrl", ctrl_out,  3'b111);
        rst = 1'b1; flush = 1'b1;
        drive(1'b1, 3'b101, 16'h0099, 3'd3);
        step();
        chk("rm_valid", out_valid, 1'b0);
        chk("rm_ctrl",  ctrl_out,  3'd0);
        chk("rm_data",  data_out,  16'h0);
        chk("rm_addr",  addr_out,  3'd0);
        chk("rm_occ",   occupancy, 2'd0);
        chk("rm_rdy_held", in_ready, 1'b0);
        step();
        chk("rm_rdy_held2", in_ready,  1'b0);
        chk("rm_occ2",      occupancy, 2'd0);
        rst = 1'b0; flush = 1'b0;
        drive(1'b0, 3'd0, 16'h0, 3'd0);
        #1;
        chk("rm_rdy_release", in_ready, 1'b1);

        // ---- random valid/ready with scoreboard ----
        model_occ = 0;
        n_in = 0;
        n_out = 0;
        cycles = 0;
        while ((n_in < 1000 || model_occ != 0) && cycles < 20000) begin
            step();
            cycles++;
            in_valid  = (n_in < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            out_ready = (n_in < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
            ctrl_in   = 3'($urandom);
            data_in   = 16'($urandom);
            addr_in   = 3'($urandom);
            #1;
            chk("rnd_occ",   occupancy, model_occ[1:0]);
            chk("rnd_rdy",   in_ready,  (model_occ != 2));
            chk("rnd_valid", out_valid, (model_occ != 0));
            do_push = in_valid && (model_occ != 2);
            do_pop  = out_ready && (model_occ != 0);
            if (do_pop) begin
                exp_word = sb_q.pop_front();
                chk("rnd_word", {ctrl_out, data_out, addr_out}, exp_word);
                n_out++;
            end
            if (do_push) begin
                sb_q.push_back({ctrl_in, data_in, addr_in});
                n_in++;
            end
            model_occ = model_occ + int'(do_push) - int'(do_pop);
        end
        drive(1'b0, 3'd0, 16'h0, 3'd0);
        chk("rnd_words_in",  n_in,  1000);
        chk("rnd_words_out", n_out, 1000);
        step();
        chk("rnd_final_occ", occupancy, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mw_skid_buffer.md
Name: mw_skid_buffer

Overview:
- Parametrised successor to the memory/write-back stage register.
- Carries control, ALU data and write address from the memory stage to the write-back stage.
- Adds a valid/ready handshake, a 2-entry skid store so back-pressure never drops a word, and a synchronous flush that forms a bubble.
- Sits between the memory-stage output and the write-back/register-file write port.

Parameters:
- CTRL_W, 3, width of control-signal bundle
- DATA_W, 16, width of ALU/memory result
- ADDR_W, 3, width of destination register address

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous squash of all held entries
- in_valid  in  1  upstream word present
- in_ready  out  1  buffer accepts a word this cycle
- ctrl_in  in  CTRL_W  control signals from memory stage
- data_in  in  DATA_W  ALU/memory result
- addr_in  in  ADDR_W  destination register address
- out_valid  out  1  output word present
- out_ready  in  1  write-back stage consumes the word
- ctrl_out  out  CTRL_W  control signals to write-back
- data_out  out  DATA_W  result to write-back
- addr_out  out  ADDR_W  destination address to write-back
- occupancy  out  2  entries held (0..2)

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high, with priority over everything else.
- Storage:
  - main entry drives the outputs.
  - skid entry holds one overflow word.
  - State is EMPTY(0), ONE(1) or FULL(2); `occupancy` equals the state encoding.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = (state != FULL) & !rst, decoded from registered state only, with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
- Latency: 1 cycle. A word pushed into EMPTY at edge N is on the outputs with out_valid=1 after edge N.
- Transitions, with flush=0:
  - EMPTY + push -> ONE; main <= inputs.
  - ONE + push + pop -> ONE; main <= inputs.
  - ONE + push, no pop -> FULL; skid <= inputs, main unchanged.
  - ONE + pop, no push -> EMPTY.
  - FULL + pop -> ONE; main <= skid. No push is possible because in_ready=0.
  - Otherwise state and entries hold.
- Ordering: words leave in exactly the order they were pushed; none is duplicated or lost.
- Output gating:
  - ctrl_out = 0 whenever out_valid=0, so an empty buffer presents a bubble with all write enables low.
  - data_out and addr_out show main's contents while out_valid=0 and are don't-care to consumers.
- Flush (priority below rst, above push/pop):
  - At the edge, state -> EMPTY and both entries are invalidated.
  - A push or pop offered in the flush cycle has no effect; the offered input word is discarded.
  - data/addr registers hold their values; ctrl_out reads 0 from the next cycle.
  - in_ready=1 in the cycle after flush.
- Reset:
  - At the edge, state=EMPTY, all data/addr/ctrl registers=0.
  - Outputs after reset: out_valid=0, ctrl_out=0, data_out=0, addr_out=0, occupancy=0, in_ready=1.
  - While rst is high, in_ready=0 and inputs are ignored.
  - Reset mid-transfer drops any held entries.
- rst and flush together: reset wins; the result is identical to reset alone.

Test Plan:
- Stream with out_ready=1:
  - Stimulus: after reset, push ctrl=3'b101, data=16'hA5A5, addr=3'd4, then ctrl=3'b011, data=16'h1234, addr=3'd2 back-to-back.
  - Required: each word appears on the outputs exactly one cycle after its push edge, out_valid=1, occupancy stays at 1, in_ready stays 1.
- Back-pressure:
  - Stimulus: hold out_ready=0 and push 16'h0001, 16'h0002.
  - Required: occupancy=2, in_ready=0, data_out=16'h0001, and a third offered word is not accepted.
  - Then raise out_ready: outputs are 16'h0001, 16'h0002, then out_valid=0, ctrl_out=0.
- Flush while FULL:
  - Stimulus: with occupancy=2, assert flush together with in_valid=1, data=16'hBEEF.
  - Required: next cycle occupancy=0, out_valid=0, ctrl_out=0, in_ready=1; 16'hBEEF never appears.
- Reset mid-operation:
  - Stimulus: with occupancy=1 and ctrl_out=3'b111, assert rst together with flush and in_valid.
  - Required: next cycle all outputs 0, in_ready=0 while rst is held, then in_ready=1 after release.
- Randomised valid/ready with a scoreboard:
  - Stimulus: 1000 words, random in_valid/out_ready, no flush.
  - Required: output sequence equals input sequence and occupancy never exceeds 2.
